// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM state encoding, default baud
// divisor and the fixed 8N1 frame constants.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t ST_IDLE  = 2'd0;
    localparam tx_state_t ST_START = 2'd1;
    localparam tx_state_t ST_DATA  = 2'd2;
    localparam tx_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte buffer feeding the UART transmitter; power-of-two depth so the
// pointers wrap naturally.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    parameter  int WIDTH      = DATA_BITS,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and are
// serialised LSB first, back to back with no idle gap when more are waiting.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       uart_txd,
    output logic       busy
);

    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t         state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
    logic              ready_en;
    logic              bit_end;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic [7:0]        fifo_dout;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ready_en keeps the input closed while in reset and opens it on the first edge after.
    assign data_in_ready = ready_en && !fifo_full;
    assign push          = data_in_valid && data_in_ready;
    assign bit_end       = (bit_cnt == BIT_LAST);

    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: pop = !fifo_empty;
            ST_STOP: pop = bit_end && (bit_idx == STOP_LAST) && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            bit_cnt <= (state == ST_IDLE || bit_end) ? '0 : bit_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift_reg <= fifo_dout;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            state   <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (pop) begin
                                shift_reg <= fifo_dout;
                                state     <= ST_START;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Line and busy are registered from the current state, so both lag the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_txd <= 1'b1;
            busy     <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            busy     <= (state != ST_IDLE) || (fifo_count != '0);
            case (state)
                ST_START: uart_txd <= 1'b0;
                ST_DATA:  uart_txd <= shift_reg[0];
                default:  uart_txd <= 1'b1;
            endcase
        end
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL expose parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit (50 MHz / 115 200 baud).
REQ-002 The block SHALL expose parameter FIFO_DEPTH, default 4, giving byte-buffer entries (power of two, >= 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_in, input, 8 bits: the byte to transmit.
REQ-006 The block SHALL have port data_in_valid, input, 1 bit: data_in is offered.
REQ-007 The block SHALL have port data_in_ready, output, 1 bit: the buffer can accept a byte.
REQ-008 The block SHALL have port uart_txd, output, 1 bit: serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress or the buffer is non-empty.

Function
REQ-010 The block SHALL accept a byte on a clock edge where data_in_valid and data_in_ready are both 1; there is no other write path.
REQ-011 data_in_ready SHALL be 0 when the buffer holds FIFO_DEPTH bytes and 1 otherwise, from registered count only, with no same-cycle pop bypass.
REQ-012 An offer while data_in_ready is 0 SHALL be ignored, with no data or state change; the producer holds data_in_valid.
REQ-013 The buffer SHALL be first-in first-out, with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-014 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-015 In IDLE with the buffer non-empty, the FSM SHALL pop the head byte into a shift register and enter START on the same edge.
REQ-016 A byte accepted at edge k into an empty buffer with the FSM in IDLE SHALL drive uart_txd low from edge k+2.
REQ-017 uart_txd SHALL be a registered output: 1 in IDLE and STOP, 0 in START, and the current data bit in DATA.
REQ-018 Each of START, each DATA bit and STOP SHALL hold uart_txd for exactly CLKS_PER_BIT cycles.
REQ-019 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and clear on every bit boundary.
REQ-020 DATA SHALL send 8 bits LSB first, tracked by a 3-bit index that ends the state after index 7.
REQ-021 At the end of STOP, the FSM SHALL pop the next byte and enter START directly if the buffer is non-empty, giving zero idle gap; otherwise it SHALL enter IDLE.
REQ-022 A simultaneous push and pop SHALL leave the count unchanged and store the pushed byte correctly, including at wrap-around.
REQ-023 busy SHALL be registered, and equal 1 when the FSM is not in IDLE or the count is non-zero.
REQ-024 The frame format SHALL be fixed at 8N1 with no parity.

Reset
REQ-025 Asserting rst_n low SHALL immediately force uart_txd=1, busy=0, data_in_ready=0, FSM=IDLE, and counters, pointers and count to 0.
REQ-026 Reset SHALL abort any frame in progress and flush buffered bytes; the line goes high without a completed stop bit.
REQ-027 data_in_ready SHALL go to 1 on the first clk edge after rst_n deasserts.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum, the default CLKS_PER_BIT, and the frame constants (8 data bits, 1 stop bit).
REQ-029 The buffer SHALL be a separate sub-module uart_tx_fifo (parameter FIFO_DEPTH, push/pop/full/empty/count), instantiated once.
REQ-030 The target size SHALL be 120-400 lines of RTL in total.

Verification
REQ-031 With CLKS_PER_BIT=4, push 0xA5: uart_txd low at edge k+2, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high; busy falls after STOP.
REQ-032 Push 0x00 then 0xFF back-to-back: two frames totalling 20 bit-times with no idle cycle between the first stop bit and the second start bit.
REQ-033 Hold data_in_valid for 6 bytes (0x01..0x06) with FIFO_DEPTH=4: ready drops after the 4th accepted byte (5th if a pop occurred), and all six bytes are transmitted in order.
REQ-034 Push and pop on the same cycle with the buffer holding 3 bytes and pointers at wrap: the count stays 3, and the output order is preserved.
REQ-035 Assert rst_n low during DATA bit 3 of 0x5A: uart_txd=1 and busy=0 in the same cycle; after release, push 0x3C and observe one correct frame with no residue of 0x5A.
REQ-036 Offer 0x77 while ready=0: the byte is not accepted until ready=1, and exactly one 0x77 frame is sent.
